// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared types and defaults for the 2-read/1-write register file.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   RD_ADDR_MAX_W           : width of the raddr field in rd_port_t; ADDR_W must not exceed it
//   clr_state_e             : bulk-clear sequencer states
//   rd_port_t               : read-port request (enable + address)
package regfile_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 3;
  localparam int RD_ADDR_MAX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  // raddr is sized for the largest supported array; narrower addresses are zero-extended.
  typedef struct packed {
    logic                     re;
    logic [RD_ADDR_MAX_W-1:0] raddr;
  } rd_port_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq -- bulk-clear sequencer for reg_file_2r1w.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_req   : level-sampled clear request (honoured only in IDLE)
//   clr_busy  : high while entries are being cleared (one entry per cycle)
//   clr_done  : one-cycle pulse after the last entry is cleared
//   clr_stb   : array clear strobe for entry clr_idx this cycle
//   clr_idx   : entry being cleared
//
// state    | meaning
// ST_IDLE  | waiting for clr_req; writes accepted
// ST_CLEAR | clearing entry idx, one per cycle, NUM_REGS cycles total
// ST_DONE  | clr_done pulse for one cycle; writes accepted
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_stb,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Stop on the last entry so idx never wraps within a sequence.
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_stb  = 1'b0;
    clr_idx  = idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_busy = 1'b1;
        clr_stb  = 1'b1;
      end
      ST_DONE: begin
        clr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w -- register file with two registered read ports, one write port
// and a sequenced bulk clear.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   we/waddr/wdata    : write port (writes dropped while clr_busy)
//   re_a/raddr_a      : read port A request; rdata_a valid one cycle later, held when re_a=0
//   re_b/raddr_b      : read port B request; rdata_b valid one cycle later, held when re_b=0
//   clr_req           : start bulk clear of all entries
//   clr_busy/clr_done : clear in progress / one-cycle completion pulse
// Build option:
//   REGFILE_BYPASS_EN : defined -> write-first (an accepted write is forwarded to a
//                       same-address read); undefined -> read-first (old value read).
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

  logic              clr_stb;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_en;
  rd_port_t          rd_a, rd_b;

  regfile_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_stb  (clr_stb),
    .clr_idx  (clr_idx)
  );

  // A write in the IDLE cycle that raises clr_req is still accepted, since busy
  // only goes high on the following edge.
  assign wr_en = we & ~clr_busy;

  always_comb begin
    rd_a.re    = re_a;
    rd_a.raddr = RD_ADDR_MAX_W'(raddr_a);
    rd_b.re    = re_b;
    rd_b.raddr = RD_ADDR_MAX_W'(raddr_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_stb) begin
      mem_q[clr_idx] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a_d = rdata_a_q;
    if (rd_a.re) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_a.raddr == RD_ADDR_MAX_W'(i)) begin
          rdata_a_d = mem_q[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (rd_a.raddr == RD_ADDR_MAX_W'(waddr))) begin
        rdata_a_d = wdata;
      end
`endif
    end
  end

  always_comb begin
    rdata_b_d = rdata_b_q;
    if (rd_b.re) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_b.raddr == RD_ADDR_MAX_W'(i)) begin
          rdata_b_d = mem_q[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (rd_b.raddr == RD_ADDR_MAX_W'(waddr))) begin
        rdata_b_d = wdata;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic        re_a;
  logic [2:0]  raddr_a;
  logic [31:0] rdata_a;
  logic        re_b;
  logic [2:0]  raddr_b;
  logic [31:0] rdata_b;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  reg_file_2r1w #(
    .DATA_W (32),
    .ADDR_W (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re_a     (re_a),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .re_b     (re_b),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic        re_a;
    logic [2:0]  raddr_a;
    logic        re_b;
    logic [2:0]  raddr_b;
    logic        chk;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] COLL_A = 32'h0000_0022;
`else
  localparam logic [31:0] COLL_A = 32'h0000_0011;
`endif

  localparam int NV = 9;
  vec_t vecs [NV];

  int n_chk  = 0;
  int n_pass = 0;

  int          busy_n;
  int          done_n;
  bit          finished;
  bit          got7;
  logic [31:0] rd7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic cycle(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                       input logic ea, input logic [2:0] ra,
                       input logic eb, input logic [2:0] rb);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd;
    re_a = ea; raddr_a = ra;
    re_b = eb; raddr_b = rb;
    @(posedge clk);
    #1;
  endtask

  // Reads every entry once on each port; entry 4 may carry a non-zero value.
  task automatic read_all(input string tag, input logic [31:0] val4);
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  ia;
      logic [2:0]  ib;
      logic [31:0] ea;
      logic [31:0] eb;
      ia = 3'(i);
      ib = 3'(7 - i);
      ea = (i == 4) ? val4 : 32'h0;
      eb = ((7 - i) == 4) ? val4 : 32'h0;
      cycle(1'b0, 3'd0, 32'h0, 1'b1, ia, 1'b1, ib);
      check($sformatf("%s_a%0d", tag, i), rdata_a, ea);
      check($sformatf("%s_b%0d", tag, 7 - i), rdata_b, eb);
    end
  endtask

  // Starts just after the edge that entered CLEAR; counts busy cycles and done
  // pulses, and looks one cycle past DONE for a stray second pulse.
  task automatic count_clear(output int b, output int d, output bit ok);
    b = 0; d = 0; ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (clr_busy) b++;
      if (clr_done) d++;
      if (ok) break;
      if (clr_done) ok = 1;
      @(negedge clk);
      clr_req = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"wr3",      1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h0,          32'h0};
    vecs[1] = '{"wr7",      1'b1, 3'd7, 32'h1234_5678, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h0,          32'h0};
    vecs[2] = '{"rd3_7",    1'b0, 3'd0, 32'h0,         1'b1, 3'd3, 1'b1, 3'd7, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[3] = '{"hold",     1'b1, 3'd3, 32'h0,         1'b0, 3'd3, 1'b0, 3'd7, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[4] = '{"rd3_3",    1'b0, 3'd0, 32'h0,         1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 32'h0,          32'h0};
    vecs[5] = '{"wr5",      1'b1, 3'd5, 32'h11,        1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h0,          32'h0};
    vecs[6] = '{"collide",  1'b1, 3'd5, 32'h22,        1'b1, 3'd5, 1'b1, 3'd7, 1'b1, COLL_A,         32'h1234_5678};
    vecs[7] = '{"rd5_5",    1'b0, 3'd0, 32'h0,         1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 32'h22,         32'h22};
    vecs[8] = '{"rd0_1",    1'b0, 3'd0, 32'h0,         1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 32'h0,          32'h0};

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0; clr_req = 1'b0;
    #1;
    check("rst_rdata_a", rdata_a, 32'h0);
    check("rst_rdata_b", rdata_b, 32'h0);
    check("rst_busy", {31'h0, clr_busy}, 32'h0);
    check("rst_done", {31'h0, clr_done}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      cycle(vecs[k].we, vecs[k].waddr, vecs[k].wdata,
            vecs[k].re_a, vecs[k].raddr_a, vecs[k].re_b, vecs[k].raddr_b);
      if (vecs[k].chk) begin
        check({vecs[k].name, "_a"}, rdata_a, vecs[k].exp_a);
        check({vecs[k].name, "_b"}, rdata_b, vecs[k].exp_b);
      end
    end

    // Asynchronous reset after writes: outputs clear without waiting for an edge.
    cycle(1'b0, 3'd0, 32'h0, 1'b1, 3'd7, 1'b1, 3'd5);
    check("pre_rst_a", rdata_a, 32'h1234_5678);
    check("pre_rst_b", rdata_b, 32'h22);
    @(negedge clk);
    re_a = 1'b0; re_b = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_rdata_a", rdata_a, 32'h0);
    check("arst_rdata_b", rdata_b, 32'h0);
    check("arst_busy", {31'h0, clr_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    read_all("post_rst", 32'h0);

    // Bulk clear with a mid-sequence read, a dropped write, and a write in DONE.
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 32'hA5A5_A5A5, 1'b0, 3'd0, 1'b0, 3'd0);
    @(negedge clk);
    we = 1'b0; clr_req = 1'b1;
    @(posedge clk);
    #1;
    check("clr_start_busy", {31'h0, clr_busy}, 32'h1);
    busy_n = 0; done_n = 0; finished = 0; got7 = 0; rd7 = '0;
    for (int c = 0; c < 20 && !finished; c++) begin
      logic was_busy3;
      if (clr_busy) busy_n++;
      if (clr_done) done_n++;
      was_busy3 = clr_busy && (busy_n == 3);
      @(negedge clk);
      clr_req = 1'b0; we = 1'b0; re_a = 1'b0; re_b = 1'b0;
      if (was_busy3) begin re_a = 1'b1; raddr_a = 3'd7; end
      if (clr_busy && busy_n == 5) begin we = 1'b1; waddr = 3'd2; wdata = 32'hFF; end
      if (clr_done) begin we = 1'b1; waddr = 3'd4; wdata = 32'h5A5A_5A5A; finished = 1; end
      @(posedge clk);
      #1;
      if (was_busy3 && !got7) begin rd7 = rdata_a; got7 = 1; end
    end
    check("clr_finished", {31'h0, finished}, 32'h1);
    check("clr_busy_cycles", 32'(busy_n), 32'd8);
    check("clr_done_pulses", 32'(done_n), 32'd1);
    check("clr_rd7_mid", rd7, 32'hA5A5_A5A5);
    cycle(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    check("clr_after_busy", {31'h0, clr_busy}, 32'h0);
    check("clr_after_done", {31'h0, clr_done}, 32'h0);
    read_all("post_clr", 32'h5A5A_5A5A);

    // Reset in the 4th CLEAR cycle aborts the sequence without a done pulse.
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 32'h3C00 + 32'(i), 1'b0, 3'd0, 1'b0, 3'd0);
    @(negedge clk);
    we = 1'b0; clr_req = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      clr_req = 1'b0;
      @(posedge clk);
      #1;
    end
    check("mid_clr4_busy", {31'h0, clr_busy}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, clr_busy}, 32'h0);
    check("mid_rst_done", {31'h0, clr_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (clr_done) done_n++;
    end
    check("mid_rst_no_done", 32'(done_n), 32'd0);
    read_all("mid_rst", 32'h0);

    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    count_clear(busy_n, done_n, finished);
    check("reclr_finished", {31'h0, finished}, 32'h1);
    check("reclr_busy_cycles", 32'(busy_n), 32'd8);
    check("reclr_done_pulses", 32'(done_n), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
